alu_rf: RTL and testbench
=========================

# alu_rf

Combined datapath core for the RV32I pipeline: a 32×32-bit register file with two combinational read ports and one synchronous write port, plus a 32-bit combinational ALU selected by a 5-bit operation code. The register file serves the ID stage (reads) and the WB stage (write). The ALU serves the EX stage. The two units share only CLK/RST and are otherwise independent.

## Interface

Parameters:
- none; data width fixed at 32 bits, 32 registers, 5-bit op code.

Ports:
- CLK  input  1  clock; register-file writes occur on its rising edge.
- RST  input  1  asynchronous, active-high reset; clears all registers.
- RNUM1  input  5  read port 1 register index.
- RDATA1  output  32  read port 1 data.
- RNUM2  input  5  read port 2 register index.
- RDATA2  output  32  read port 2 data.
- WNUM  input  5  write register index; 0 means no write.
- WDATA  input  32  write data.
- A  input  32  ALU operand 1.
- B  input  32  ALU operand 2; B[4:0] is the shift amount for shifts.
- C  input  5  ALU operation code.
- Y  output  32  ALU result.

## Operation

Register file:
- RDATAn = reg[RNUMn]; combinational, no clock.
- Index 0 always reads 0 and is never written.
- On posedge CLK with WNUM≠0: reg[WNUM] ← WDATA. WNUM=0 is the write-disable encoding, used by the pipeline as RegWrite ? RD : 0.
- No internal write→read bypass. A read of the register being written returns the old value until the edge and the new value after it.
- RST asserted: all 31 writable registers are cleared to 0 immediately, regardless of CLK. Writes are ignored while RST is high.

ALU (purely combinational, modulo 2^32). C encodings are the team values in alu.vh:
- 0 IADD: A+B
- 1 ISUB: A−B
- 2 IAND: A&B
- 3 IOR: A|B
- 4 IXOR: A^B
- 5 ISLL: A << B[4:0]
- 6 ISRL: A >> B[4:0], logical
- 7 ISRA: A >>> B[4:0], arithmetic with A[31] fill
- 8 ISLT: signed A<B, result {31'b0, lt}
- 9 ISLTU: unsigned A<B, result {31'b0, lt}
- 10 IPASSB: B (used for LUI)
- 11 IEQ: {31'b0, A==B}
- 12 INE: {31'b0, A!=B}
- 13 IGE: {31'b0, signed A>=B}
- 14 IGEU: {31'b0, unsigned A>=B}
- any other C: Y = 0.

Additional rules:
- Overflow is discarded, with no flags.
- B[31:5] is ignored for shifts.

## Timing

- RDATA1/RDATA2 follow RNUM changes and register state with zero-cycle latency.
- A write is visible on the read ports one CLK edge after it is presented: after the edge, same delta-cycle settle.
- Y follows A/B/C combinationally with no registers. Y has no reset value and depends only on its inputs.
- Reset values:
  - all registers 0;
  - RDATA1/RDATA2 = 0 for any RNUM while and after reset, until a write occurs.
- Reset mid-write: if RST rises in the same cycle as a pending write, the write is lost. A write whose edge coincides with RST high is ignored.
- Back-to-back writes to the same index on consecutive edges: the last one wins.

## Test plan

- Reset then read: assert RST, read RNUM1=5, RNUM2=31 → both 0. Write 0xDEADBEEF to x7, pulse RST asynchronously mid-cycle → x7 reads 0 at once.
- Write/read and x0: WNUM=3, WDATA=0x12345678, edge → RDATA1(RNUM1=3)=0x12345678. WNUM=0, WDATA=0xFFFFFFFF, edge → RNUM1=0 reads 0 and no other register changes.
- Read-during-write: x4=0x1, then present WNUM=4, WDATA=0x2 with RNUM2=4 → RDATA2=0x1 before the edge, 0x2 after it.
- Arithmetic/logic:
  - A=0xFFFFFFFF, B=1, IADD → 0. ISUB with A=0, B=1 → 0xFFFFFFFF.
  - A=0xF0F0F0F0, B=0x0FF00FF0: AND → 0x00F000F0, OR → 0xFFF0FFF0, XOR → 0xFF00FF00.
- Shifts:
  - A=0x80000001, B=0x00000021 (shamt 1): ISLL → 0x00000002, ISRL → 0x40000000, ISRA → 0xC0000000.
- Compares:
  - A=0xFFFFFFFF, B=1: ISLT → 1, ISLTU → 0, IGE → 0, IGEU → 1.
  - A=B=5: IEQ → 1, INE → 0.
  - IPASSB with B=0xABCDE000 → 0xABCDE000.
  - C=31 → 0.

Source files
------------

// File: rtl/alu_rf.sv
// rtl/alu_rf.sv - RV32I datapath core: 32x32 register file plus combinational ALU
//
// Purpose:
//   Register file (two combinational read ports, one synchronous write port)
//   for the ID/WB stages, and a 32-bit combinational ALU for the EX stage.
//   The two halves share only CLK/RST.
//
// Ports:
//   CLK     in   1   clock; register writes on rising edge
//   RST     in   1   asynchronous active-high reset; clears all registers
//   RNUM1   in   5   read port 1 index
//   RDATA1  out  32  read port 1 data (x0 reads 0)
//   RNUM2   in   5   read port 2 index
//   RDATA2  out  32  read port 2 data (x0 reads 0)
//   WNUM    in   5   write index; 0 disables the write
//   WDATA   in   32  write data
//   A       in   32  ALU operand 1
//   B       in   32  ALU operand 2; B[4:0] is the shift amount
//   C       in   5   ALU operation code
//   Y       out  32  ALU result

module alu_rf (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  RNUM1,
  output logic [31:0] RDATA1,
  input  logic [4:0]  RNUM2,
  output logic [31:0] RDATA2,
  input  logic [4:0]  WNUM,
  input  logic [31:0] WDATA,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  C,
  output logic [31:0] Y
);

  localparam logic [4:0] IADD   = 5'd0;
  localparam logic [4:0] ISUB   = 5'd1;
  localparam logic [4:0] IAND   = 5'd2;
  localparam logic [4:0] IOR    = 5'd3;
  localparam logic [4:0] IXOR   = 5'd4;
  localparam logic [4:0] ISLL   = 5'd5;
  localparam logic [4:0] ISRL   = 5'd6;
  localparam logic [4:0] ISRA   = 5'd7;
  localparam logic [4:0] ISLT   = 5'd8;
  localparam logic [4:0] ISLTU  = 5'd9;
  localparam logic [4:0] IPASSB = 5'd10;
  localparam logic [4:0] IEQ    = 5'd11;
  localparam logic [4:0] INE    = 5'd12;
  localparam logic [4:0] IGE    = 5'd13;
  localparam logic [4:0] IGEU   = 5'd14;

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  // Entry 0 exists only to keep indexing simple; it is reset and never
  // written, and reads of index 0 are forced to zero regardless.
  logic [31:0] r_regs [0:31];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (WNUM != 5'd0) begin
      r_regs[WNUM] <= WDATA;
    end
  end

  // No write-to-read bypass: reads see the stored value until the edge.
  assign RDATA1 = (RNUM1 == 5'd0) ? 32'd0 : r_regs[RNUM1];
  assign RDATA2 = (RNUM2 == 5'd0) ? 32'd0 : r_regs[RNUM2];

  // ---------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------
  logic [4:0]  w_shamt;
  logic        w_lt_s;
  logic        w_lt_u;
  logic        w_eq;

  assign w_shamt = B[4:0];
  assign w_lt_s  = $signed(A) < $signed(B);
  assign w_lt_u  = A < B;
  assign w_eq    = (A == B);

  always_comb begin
    Y = 32'd0;
    case (C)
      IADD:   Y = A + B;
      ISUB:   Y = A - B;
      IAND:   Y = A & B;
      IOR:    Y = A | B;
      IXOR:   Y = A ^ B;
      ISLL:   Y = A << w_shamt;
      ISRL:   Y = A >> w_shamt;
      ISRA:   Y = $unsigned($signed(A) >>> w_shamt);
      ISLT:   Y = {31'd0, w_lt_s};
      ISLTU:  Y = {31'd0, w_lt_u};
      IPASSB: Y = B;
      IEQ:    Y = {31'd0, w_eq};
      INE:    Y = {31'd0, ~w_eq};
      IGE:    Y = {31'd0, ~w_lt_s};
      IGEU:   Y = {31'd0, ~w_lt_u};
      default: Y = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_alu_rf.sv
// tb/tb_alu_rf.sv - scoreboard testbench for alu_rf with random and directed stimulus

module tb_alu_rf;

  logic        CLK;
  logic        RST;
  logic [4:0]  RNUM1, RNUM2, WNUM, C;
  logic [31:0] RDATA1, RDATA2, WDATA, A, B, Y;

  alu_rf dut (
    .CLK(CLK), .RST(RST),
    .RNUM1(RNUM1), .RDATA1(RDATA1),
    .RNUM2(RNUM2), .RDATA2(RDATA2),
    .WNUM(WNUM), .WDATA(WDATA),
    .A(A), .B(B), .C(C), .Y(Y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          step;
    int          kind;   // 0: Y, 1: RDATA1, 2: RDATA2
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_rf [32];
  int          total = 0;
  int          bad   = 0;
  int          step_no = 0;
  logic        obs_valid = 1'b0;
  logic        stim_done = 1'b0;

  // Reference ALU computed from the operation meanings with wide arithmetic.
  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [4:0] c);
    longint ua, ub, sa, sb2, p, q;
    int sh;
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    sa  = a[31] ? ua - 64'sh1_0000_0000 : ua;
    sb2 = b[31] ? ub - 64'sh1_0000_0000 : ub;
    sh  = int'(ub % 32);
    p   = longint'(1) << sh;
    case (c)
      5'd0:  return 32'(ua + ub);
      5'd1:  return 32'(ua - ub);
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return 32'(ua * p);
      5'd6:  return 32'(ua / p);
      5'd7: begin
        if (sa >= 0) q = sa / p;
        else         q = -((-sa + p - 1) / p);
        return 32'(q);
      end
      5'd8:  return (sa < sb2)  ? 32'd1 : 32'd0;
      5'd9:  return (ua < ub)   ? 32'd1 : 32'd0;
      5'd10: return b;
      5'd11: return (a == b)    ? 32'd1 : 32'd0;
      5'd12: return (a != b)    ? 32'd1 : 32'd0;
      5'd13: return (sa >= sb2) ? 32'd1 : 32'd0;
      5'd14: return (ua >= ub)  ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // One step: drive inputs shortly after a rising edge, predict the outputs
  // seen before the next edge, then apply the write the next edge performs.
  task automatic step(input logic rst, input logic [4:0] rn1, input logic [4:0] rn2,
                      input logic [4:0] wn, input logic [31:0] wd,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] c);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst; RNUM1 = rn1; RNUM2 = rn2; WNUM = wn; WDATA = wd; A = a; B = b; C = c;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end
    step_no++;
    e.step = step_no;
    e.kind = 0; e.exp = ref_alu(a, b, c); sb.push_back(e);
    e.kind = 1; e.exp = (rn1 == 0) ? 32'd0 : m_rf[rn1]; sb.push_back(e);
    e.kind = 2; e.exp = (rn2 == 0) ? 32'd0 : m_rf[rn2]; sb.push_back(e);
    obs_valid = 1'b1;
    if (!rst && wn != 0) m_rf[wn] = wd;
  endtask

  // Monitor: pops three expectations per observed step on the falling edge.
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge CLK);
      if (obs_valid) begin
        obs_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_underflow: step=%0d scoreboard empty", step_no);
          end else begin
            e = sb.pop_front();
            act = (e.kind == 0) ? Y : (e.kind == 1) ? RDATA1 : RDATA2;
            if (act !== e.exp) begin
              bad++;
              $display("FAIL %s step=%0d: got %08h expected %08h",
                       (e.kind == 0) ? "Y" : (e.kind == 1) ? "RDATA1" : "RDATA2",
                       e.step, act, e.exp);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    RST = 1'b1; RNUM1 = 0; RNUM2 = 0; WNUM = 0; WDATA = 0; A = 0; B = 0; C = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;

    // Reset then read, with a write attempted under reset.
    step(1, 5'd5, 5'd31, 5'd6, 32'h1111_1111, 32'hFFFF_FFFF, 32'd1, 5'd0);
    step(0, 5'd6, 5'd31, 5'd7, 32'hDEAD_BEEF, 32'd0, 32'd1, 5'd1);
    step(0, 5'd7, 5'd6, 5'd0, 32'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd2);
    // Async reset mid-cycle clears x7 immediately; write to x9 ignored.
    step(1, 5'd7, 5'd9, 5'd9, 32'h0000_0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd3);
    step(0, 5'd7, 5'd9, 5'd3, 32'h1234_5678, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd4);
    // x0 write is discarded, x3 unchanged.
    step(0, 5'd3, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0021, 5'd5);
    step(0, 5'd0, 5'd3, 5'd4, 32'h0000_0001, 32'h8000_0001, 32'h0000_0021, 5'd6);
    // Read-during-write on x4: old value before the edge, new value after.
    step(0, 5'd3, 5'd4, 5'd4, 32'h0000_0002, 32'h8000_0001, 32'h0000_0021, 5'd7);
    step(0, 5'd0, 5'd4, 5'd5, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'd1, 5'd8);
    // Back-to-back writes to x5: the last one wins.
    step(0, 5'd5, 5'd4, 5'd5, 32'h5555_5555, 32'hFFFF_FFFF, 32'd1, 5'd9);
    step(0, 5'd5, 5'd5, 5'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 5'd13);
    step(0, 5'd1, 5'd2, 5'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 5'd14);
    step(0, 5'd1, 5'd2, 5'd0, 32'd0, 32'd5, 32'd5, 5'd11);
    step(0, 5'd1, 5'd2, 5'd0, 32'd0, 32'd5, 32'd5, 5'd12);
    step(0, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'hABCD_E000, 5'd10);
    step(0, 5'd1, 5'd2, 5'd0, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd31);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra, rb;
      logic [4:0]  rc;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 4) == 0) ra = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'd0};
      rc = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           5'($urandom), 5'($urandom),
           ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
           $urandom, ra, rb, rc);
    end

    stim_done = 1'b1;
    for (int i = 0; i < 10 && (sb.size() > 0 || obs_valid); i++) @(posedge CLK);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
